// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment readback path: active-low glyph codes and FSM states.
package seg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int IDX_W      = $clog2(MAX_DIGITS);

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_t;

endpackage

// File: rtl/seg_pattern_to_hex.sv
// Combinational inverse glyph lookup: pattern -> nibble, with known/blank flags.
module seg_pattern_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_nibble,
  output logic       o_known,
  output logic       o_blank
);

  always_comb begin
    o_nibble = 4'h0;
    o_known  = 1'b1;
    o_blank  = 1'b0;
    case (i_pattern)
      SEG_0:     o_nibble = 4'h0;
      SEG_1:     o_nibble = 4'h1;
      SEG_2:     o_nibble = 4'h2;
      SEG_3:     o_nibble = 4'h3;
      SEG_4:     o_nibble = 4'h4;
      SEG_5:     o_nibble = 4'h5;
      SEG_6:     o_nibble = 4'h6;
      SEG_7:     o_nibble = 4'h7;
      SEG_8:     o_nibble = 4'h8;
      SEG_9:     o_nibble = 4'h9;
      SEG_A:     o_nibble = 4'hA;
      SEG_B:     o_nibble = 4'hB;
      SEG_C:     o_nibble = 4'hC;
      SEG_D:     o_nibble = 4'hD;
      SEG_E:     o_nibble = 4'hE;
      SEG_F:     o_nibble = 4'hF;
      SEG_BLANK: begin
        o_known = 1'b0;
        o_blank = 1'b1;
      end
      default:   o_known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_display_reader.sv
// Passive multiplexed 7-segment bus monitor: stability filter, inverse glyph decode, per-digit status.
// A capture is reported one cycle after the STABLE_CYCLES-th identical registered sample.
module seg_display_reader
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   pattern_err,
  output logic                    update,
  output logic [IDX_W-1:0]        update_idx
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TGT = CW'(STABLE_CYCLES);

  logic [6:0]              r_s_seg, r_p_seg;
  logic [NUM_DIGITS-1:0]   r_s_en, r_p_en;
  state_t                  r_state, w_state_nx;
  logic [CW-1:0]           r_cnt, w_cnt_nx, w_cnt_inc;
  logic [4*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   r_valid, r_err;
  logic                    r_update;
  logic [IDX_W-1:0]        r_update_idx;

  logic [3:0]              w_zeros;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_single, w_same, w_capture;
  logic [3:0]              w_nib;
  logic                    w_known, w_blank;

  seg_pattern_to_hex u_dec (
    .i_pattern (r_s_seg),
    .o_nibble  (w_nib),
    .o_known   (w_known),
    .o_blank   (w_blank)
  );

  always_comb begin
    w_zeros = 4'd0;
    w_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_s_en[i]) begin
        w_zeros = w_zeros + 4'd1;
        w_idx   = IDX_W'(i);
      end
    end
  end

  assign w_single  = (w_zeros == 4'd1);
  assign w_same    = (r_s_seg == r_p_seg) && (r_s_en == r_p_en);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_capture  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_single) begin
          w_state_nx = COUNT;
          w_cnt_nx   = CNT_ONE;
        end
      end
      COUNT: begin
        if (w_same) begin
          w_cnt_nx = w_cnt_inc;
        end else if (w_single) begin
          w_cnt_nx = CNT_ONE;
        end else begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end
      end
      HOLD: begin
        if (!w_same) begin
          w_state_nx = w_single ? COUNT : IDLE;
          w_cnt_nx   = w_single ? CNT_ONE : '0;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
    // Reaching the target from any path (including a fresh count of 1) captures immediately.
    if (w_state_nx == COUNT && w_cnt_nx == CNT_TGT) begin
      w_capture  = 1'b1;
      w_state_nx = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s_seg      <= '0;
      r_s_en       <= '0;
      r_p_seg      <= '0;
      r_p_en       <= '0;
      r_hex        <= '0;
      r_valid      <= '0;
      r_err        <= '0;
      r_update     <= 1'b0;
      r_update_idx <= '0;
    end else begin
      r_s_seg  <= seg_in;
      r_s_en   <= dig_en_n;
      r_p_seg  <= r_s_seg;
      r_p_en   <= r_s_en;
      r_update <= w_capture;
      if (w_capture) begin
        r_update_idx <= w_idx;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && w_idx == IDX_W'(i)) begin
          if (w_known) begin
            r_hex[4*i +: 4] <= w_nib;
            r_valid[i]      <= 1'b1;
            r_err[i]        <= 1'b0;
          end else if (w_blank) begin
            r_valid[i] <= 1'b0;
            r_err[i]   <= 1'b0;
          end else begin
            r_err[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign hex_out     = r_hex;
  assign digit_valid = r_valid;
  assign pattern_err = r_err;
  assign update      = r_update;
  assign update_idx  = r_update_idx;

endmodule

// File: tb/tb_seg_display_reader.sv
// Bench for seg_display_reader: run-length reference model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_seg_display_reader;

  localparam int N = 6;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [6:0]     seg_in = 7'h00;
  logic [N-1:0]   dig_en_n = '1;
  logic [4*N-1:0] hex_out;
  logic [N-1:0]   digit_valid;
  logic [N-1:0]   pattern_err;
  logic           update;
  logic [2:0]     update_idx;

  seg_display_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .seg_in      (seg_in),
    .dig_en_n    (dig_en_n),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .pattern_err (pattern_err),
    .update      (update),
    .update_idx  (update_idx)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int pulses = 0;
  int last_pulse = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Reference model: a capture happens when the registered sample has been
  // seen on exactly S consecutive edges as a single-digit pattern.
  logic [3:0]     m_hex [N];
  logic [N-1:0]   m_valid = '0, m_err = '0;
  logic           m_upd = 1'b0;
  int             m_idx = 0;
  logic [6:0]     m_seg = '0;
  logic [N-1:0]   m_en = '0;
  int             m_run = 0;
  logic [4*N-1:0] m_hex_v;

  function automatic int one_low_pos(input logic [N-1:0] en);
    int p = 0;
    for (int i = 0; i < N; i++) if (!en[i]) p = i;
    return p;
  endfunction

  always @(posedge clk) begin
    edge_cnt++;
    if (!resetn) begin
      for (int i = 0; i < N; i++) m_hex[i] = 4'h0;
      m_valid = '0; m_err = '0; m_upd = 1'b0;
      m_seg = '0; m_en = '0; m_run = 0;
    end else begin
      m_upd = 1'b0;
      if (m_run == S) begin
        int g;
        g = -1;
        m_idx = one_low_pos(m_en);
        for (int j = 0; j < 16; j++) if (glyph[j] == m_seg) g = j;
        if (g >= 0) begin
          m_hex[m_idx] = 4'(g); m_valid[m_idx] = 1'b1; m_err[m_idx] = 1'b0;
        end else if (m_seg == 7'h7F) begin
          m_valid[m_idx] = 1'b0; m_err[m_idx] = 1'b0;
        end else begin
          m_err[m_idx] = 1'b1;
        end
        m_upd = 1'b1;
      end
      if ($countones(~dig_en_n) != 1) m_run = 0;
      else if (seg_in == m_seg && dig_en_n == m_en) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else m_run = 1;
      m_seg = seg_in; m_en = dig_en_n;
    end
    #1;
    for (int i = 0; i < N; i++) m_hex_v[4*i +: 4] = m_hex[i];
    chk("hex_out", 32'(hex_out), 32'(m_hex_v));
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("pattern_err", 32'(pattern_err), 32'(m_err));
    chk("update", 32'(update), 32'(m_upd));
    if (m_upd) chk("update_idx", 32'(update_idx), 32'(m_idx));
    if (update === 1'b1) begin
      pulses++;
      last_pulse = edge_cnt;
    end
  end

  task automatic cyc(input logic [6:0] s, input logic [N-1:0] e, input logic rn);
    seg_in = s; dig_en_n = e; resetn = rn;
    @(negedge clk);
  endtask

  initial begin
    int k, p0;
    logic [4*N-1:0] snap_hex;
    logic [N-1:0]   snap_v, snap_e;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) cyc(7'($urandom), N'($urandom), 1'b0);
    chk("rst_hex", 32'(hex_out), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_err", 32'(pattern_err), 32'h0);
    chk("rst_pulses", 32'(pulses), 32'h0);

    // Basic capture of '2' on digit 0
    k = edge_cnt + 1; p0 = pulses;
    for (int i = 0; i < 25; i++) cyc(7'h24, 6'b111110, 1'b1);
    chk("basic_pulses", 32'(pulses - p0), 32'd1);
    chk("basic_edge", 32'(last_pulse), 32'(k + 4));
    chk("basic_nib", 32'(hex_out[3:0]), 32'h2);
    chk("basic_valid0", 32'(digit_valid[0]), 32'h1);

    // Bounce 30/19 on digit 3, then settle at 19
    p0 = pulses;
    for (int t = 0; t < 5; t++) begin
      cyc((t % 2 == 0) ? 7'h30 : 7'h19, 6'b110111, 1'b1);
      cyc((t % 2 == 0) ? 7'h30 : 7'h19, 6'b110111, 1'b1);
    end
    chk("bounce_quiet", 32'(pulses - p0), 32'd0);
    k = edge_cnt + 1;
    for (int i = 0; i < 10; i++) cyc(7'h19, 6'b110111, 1'b1);
    chk("bounce_pulses", 32'(pulses - p0), 32'd1);
    chk("bounce_edge", 32'(last_pulse), 32'(k + 4));
    chk("bounce_nib", 32'(hex_out[15:12]), 32'h4);

    // Digit 5: load 9, then unknown pattern, then blank
    for (int i = 0; i < 6; i++) cyc(7'h18, 6'b011111, 1'b1);
    for (int i = 0; i < 6; i++) cyc(7'h55, 6'b011111, 1'b1);
    chk("unk_err5", 32'(pattern_err[5]), 32'h1);
    chk("unk_nib5", 32'(hex_out[23:20]), 32'h9);
    chk("unk_valid5", 32'(digit_valid[5]), 32'h1);
    p0 = pulses;
    for (int i = 0; i < 6; i++) cyc(7'h7F, 6'b011111, 1'b1);
    chk("blank_valid5", 32'(digit_valid[5]), 32'h0);
    chk("blank_err5", 32'(pattern_err[5]), 32'h0);
    chk("blank_pulses", 32'(pulses - p0), 32'd1);

    // Invalid enable patterns
    snap_hex = hex_out; snap_v = digit_valid; snap_e = pattern_err; p0 = pulses;
    for (int i = 0; i < 10; i++) cyc(7'h40, 6'b111100, 1'b1);
    for (int i = 0; i < 10; i++) cyc(7'h40, 6'b111111, 1'b1);
    chk("inv_pulses", 32'(pulses - p0), 32'd0);
    chk("inv_hex", 32'(hex_out), 32'(snap_hex));
    chk("inv_valid", 32'(digit_valid), 32'(snap_v));
    chk("inv_err", 32'(pattern_err), 32'(snap_e));

    // Reset while the count sits at 3
    k = edge_cnt + 1; p0 = pulses;
    for (int i = 0; i < 4; i++) cyc(7'h79, 6'b111101, 1'b1);
    cyc(7'h79, 6'b111101, 1'b0);
    chk("mrst_nopulse", 32'(pulses - p0), 32'd0);
    for (int i = 0; i < 6; i++) cyc(7'h79, 6'b111101, 1'b1);
    chk("mrst_pulses", 32'(pulses - p0), 32'd1);
    chk("mrst_edge", 32'(last_pulse), 32'(k + 9));
    chk("mrst_nib", 32'(hex_out[7:4]), 32'h1);
    chk("mrst_valid", 32'(digit_valid), 32'b000010);

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      logic [6:0]   s;
      logic [N-1:0] e;
      logic         rn;
      int           r, hold;
      hold = $urandom_range(1, 7);
      r = $urandom_range(0, 9);
      if (r < 7) s = glyph[$urandom_range(0, 15)];
      else if (r == 7) s = 7'h7F;
      else s = 7'($urandom);
      if ($urandom_range(0, 9) < 8) e = ~(N'(1) << $urandom_range(0, N - 1));
      else e = N'($urandom);
      rn = ($urandom_range(0, 29) != 0);
      for (int i = 0; i < hold; i++) cyc(s, e, rn);
    end
    for (int i = 0; i < 8; i++) cyc(7'h7F, '1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
